mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares one 8:1 bit-select mux among eight requesters. It registers a one-hot grant and the matching 3-bit mux select, then forwards the granted requester's data bit. An optional hold window lets a requester keep the mux for up to MAX_HOLD consecutive cycles. The block sits directly in front of the 8:1 mux and is the only driver of its select lines.

## Interface
- MAX_HOLD, 4: maximum consecutive grant cycles per requester while others wait; legal range 1..15.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; bit k is requester k; level-sensitive.
- data_i  input  8  data bits; bit k belongs to requester k.
- grant  output  8  registered one-hot grant; all zero when idle.
- sel  output  3  registered mux select; equals the index of the set grant bit.
- valid  output  1  registered; high when exactly one grant bit is set.
- data_o  output  1  data_i[sel] when valid is high, else 0; combinational from the registered sel.

## Operation
- State machine has two states, IDLE and GRANT. Registers: state, ptr[2:0] (index of the last granted requester), sel, grant, valid, hold_cnt[3:0].
- Pick function: search req starting at index (ptr+1) mod 8 and moving upward with wrap; the first set bit wins.
- IDLE:
  - req == 0: stay in IDLE.
  - Otherwise load the winner into sel, grant and ptr; set valid=1, hold_cnt=0; go to GRANT.
- GRANT, with ARB_HOLD_EN defined:
  - req[sel] == 0 and another bit of req set: move directly to the next winner, with no idle bubble; hold_cnt=0.
  - req[sel] == 0 and req == 0: go to IDLE; grant=0, valid=0. sel and ptr keep their values.
  - req[sel] == 1, hold_cnt == MAX_HOLD-1, and another requester pending: rotate to the next winner. The search starts at sel+1, so the current owner has the lowest priority. hold_cnt=0.
  - req[sel] == 1, hold_cnt == MAX_HOLD-1, no other requester: keep the grant; hold_cnt stays at MAX_HOLD-1 (saturates).
  - Otherwise keep the grant and increment hold_cnt.
- Simultaneous requests: only the rotating pointer decides; there is no fixed priority.
- A request dropped and re-raised in the same cycle is invisible, because req is sampled once per edge.
- Reset mid-grant: the grant is removed asynchronously; data_o=0 immediately.

## Timing
- Latency from req rising in IDLE to grant/valid is 1 cycle.
- Handoff from one owner to the next takes 1 edge; the grant is never zero between owners while any request is pending.
- Release latency: grant drops 1 cycle after req[sel] falls.
- data_o follows data_i with zero cycles of latency once sel is registered.
- Reset values: grant=8'h00, sel=3'd0, valid=0, data_o=0, ptr=3'd7 (first search starts at requester 0), hold_cnt=0, state=IDLE.

## Configuration
- ARB_HOLD_EN defined: the hold-window behaviour described above, using hold_cnt and MAX_HOLD.
- ARB_HOLD_EN undefined: hold_cnt is removed and MAX_HOLD is ignored. In GRANT, the block re-arbitrates every cycle from sel+1 across all requests, including the current owner at lowest priority. The effect is a strict per-cycle round-robin.

## Structure
- Shared package mux_arb_pkg holds:
  - N_REQ=8
  - SEL_W=3
  - CNT_W=4
  - the state encoding (IDLE=1'b0, GRANT=1'b1)
- Sub-module rr_pick: purely combinational. Inputs are req[7:0] and start[2:0]. Outputs are found and idx[2:0]. It is instantiated once, with start = ptr+1 in IDLE and start = sel+1 in GRANT.

## Test plan
- Reset: assert rst_n=0 mid-grant -> grant=0, valid=0, data_o=0 at once; after release, req=8'h01 -> grant=8'h01, sel=0 one cycle later.
- Single requester: req=8'h10 held 10 cycles, data_i=8'h10 -> sel=4, data_o=1 throughout; grant is not dropped (hold_cnt saturates).
- Contention: req=8'hFF from idle after reset -> grants 0,1,2,…,7,0 in turn. With ARB_HOLD_EN and MAX_HOLD=4, each owner holds exactly 4 cycles; without the macro, each holds 1 cycle.
- Early release: owner 2, others req=8'h84; drop bit 2 after 1 cycle -> grant moves to 7 on the next edge, then to 2 only after requester 7 leaves or its window expires.
- Idle return: only requester 5 active; drop req -> valid=0 one cycle later, sel stays 5; new req=8'h21 -> winner is 0 (search starts at 6 and wraps).
- Wrap-around: ptr=7, req=8'h81 -> grant=8'h01 first, then 8'h80.

Source files
------------

// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mux_arb_pkg
// Brief   : Shared sizes and FSM encoding for the round-robin mux arbiter.
// Revision: 1.0
// ============================================================================
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : mux_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin search: first set req bit at or after
//           'start', wrapping modulo N_REQ.
// Revision: 1.0
// ============================================================================
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset down so the nearest set bit is written last.
  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = start + SEL_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mux_rr_arbiter
// Brief   : Round-robin owner of an 8:1 bit-select mux; registered one-hot
//           grant and select. Define ARB_HOLD_EN for the MAX_HOLD window.
// Revision: 1.0
// ============================================================================
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data_i,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             data_o
);

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_chk
    $error("mux_rr_arbiter: MAX_HOLD must be in 1..15");
  end

  state_t           state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] sel_q;
  logic [N_REQ-1:0] grant_q;
  logic             valid_q;

  logic [SEL_W-1:0] pick_start;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             load;
  logic             release_gnt;

  assign pick_start = (state_q == IDLE) ? ptr_q + SEL_W'(1) : sel_q + SEL_W'(1);

  rr_pick u_pick (
    .req   (req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_HOLD_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt_q;
  logic             other_pend;

  assign other_pend = |(req & ~grant_q);
  // An owner still requesting only yields once its window is used up.
  assign load = pick_found &&
                ((state_q == IDLE) || !req[sel_q] ||
                 ((hold_cnt_q == HOLD_LAST) && other_pend));
`else
  assign load = pick_found;
`endif
  assign release_gnt = (state_q == GRANT) && !pick_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd7;
      sel_q      <= '0;
      grant_q    <= '0;
      valid_q    <= 1'b0;
`ifdef ARB_HOLD_EN
      hold_cnt_q <= '0;
`endif
    end else if (load) begin
      state_q    <= GRANT;
      ptr_q      <= pick_idx;
      sel_q      <= pick_idx;
      grant_q    <= N_REQ'(1) << pick_idx;
      valid_q    <= 1'b1;
`ifdef ARB_HOLD_EN
      hold_cnt_q <= '0;
`endif
    end else if (release_gnt) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      valid_q    <= 1'b0;
`ifdef ARB_HOLD_EN
    end else if ((state_q == GRANT) && (hold_cnt_q != HOLD_LAST)) begin
      hold_cnt_q <= hold_cnt_q + CNT_W'(1);
`endif
    end
  end

  assign grant  = grant_q;
  assign sel    = sel_q;
  assign valid  = valid_q;
  assign data_o = valid_q ? data_i[sel_q] : 1'b0;

endmodule : mux_rr_arbiter
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_rr_arbiter
// Brief   : Scoreboard bench for mux_rr_arbiter with an ownership-level model.
// Revision: 1.0
// ============================================================================
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_drive = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] data_i = '0;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       valid;
  logic       data_o;

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .data_i (data_i),
    .grant  (grant),
    .sel    (sel),
    .valid  (valid),
    .data_o (data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic       data;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: who owns the mux, who owned it last, and for how many cycles.
  int m_owner = -1;
  int m_last  = 7;
  int m_held  = 0;
  int m_sel   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int from);
    for (int i = 0; i < 8; i++) begin
      int k;
      k = (from + i) % 8;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic take(input int w);
    m_owner = w;
    m_last  = w;
    m_sel   = w;
    m_held  = 1;
  endtask

  task automatic model_step(input logic [7:0] r, input logic rn);
    int w;
    if (!rn) begin
      m_owner = -1; m_last = 7; m_held = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      w = pick(r, m_last + 1);
      if (w >= 0) take(w);
    end else if (!r[m_owner]) begin
      w = pick(r, m_owner + 1);
      if (w >= 0) take(w);
      else m_owner = -1;
    end else begin
`ifdef ARB_HOLD_EN
      logic [7:0] others;
      others = r & ~(8'd1 << m_owner);
      if (m_held >= MAX_HOLD) begin
        if (others != 0) take(pick(others, m_owner + 1));
      end else begin
        m_held++;
      end
`else
      take(pick(r, m_owner + 1));
`endif
    end
  endtask

  // One clock of stimulus; the expectation for the coming edge is queued.
  task automatic cycle(input logic [7:0] r, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    rst_n  = rst_drive;
    req    = r;
    data_i = d;
    model_step(r, rst_drive);
    e.valid = (m_owner >= 0);
    e.grant = e.valid ? (8'd1 << m_owner) : 8'd0;
    e.sel   = 3'(m_sel);
    e.data  = e.valid ? d[m_sel] : 1'b0;
    q.push_back(e);
  endtask

  task automatic async_reset(input int hold_cycles);
    @(posedge clk);
    #3;
    rst_drive = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("async_rst_grant", grant, 8'h00);
    chk("async_rst_valid", {7'd0, valid}, 8'h00);
    chk("async_rst_data_o", {7'd0, data_o}, 8'h00);
    for (int i = 0; i < hold_cycles; i++) cycle(8'h00, 8'($urandom));
    rst_drive = 1'b1;
  endtask

  // Monitor: compare every registered output against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("grant", grant, e.grant);
      chk("sel", {5'd0, sel}, {5'd0, e.sel});
      chk("valid", {7'd0, valid}, {7'd0, e.valid});
      chk("data_o", {7'd0, data_o}, {7'd0, e.data});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    for (int i = 0; i < 3; i++) cycle(8'h00, 8'h00);
    rst_drive = 1'b1;

    // Wrap-around from the reset pointer.
    for (int i = 0; i < 10; i++) cycle(8'h81, 8'($urandom));
    for (int i = 0; i < 2; i++) cycle(8'h00, 8'h00);

    // Single requester held; data follows data_i.
    for (int i = 0; i < 10; i++) cycle(8'h10, 8'h10);
    for (int i = 0; i < 4; i++) cycle(8'h10, 8'($urandom));

    // Reset mid-grant, then a fresh request.
    async_reset(2);
    for (int i = 0; i < 3; i++) cycle(8'h01, 8'($urandom));
    cycle(8'h00, 8'h00);

    // Full contention from idle after reset.
    async_reset(2);
    for (int i = 0; i < 40; i++) cycle(8'hFF, 8'($urandom));
    cycle(8'h00, 8'h00);

    // Early release: owner 2 with 7 waiting.
    cycle(8'h04, 8'hFF);
    cycle(8'h84, 8'h04);
    cycle(8'h80, 8'h80);
    for (int i = 0; i < 6; i++) cycle(8'h84, 8'($urandom));
    cycle(8'h04, 8'($urandom));
    cycle(8'h00, 8'h00);

    // Idle return with wrap from requester 6.
    for (int i = 0; i < 3; i++) cycle(8'h20, 8'h20);
    for (int i = 0; i < 2; i++) cycle(8'h00, 8'hFF);
    for (int i = 0; i < 3; i++) cycle(8'h21, 8'($urandom));

    // Randomised traffic with a mix of stable, toggling and sparse requests.
    r = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0: r = 8'($urandom);
        1: r = r;
        2: r = r ^ (8'd1 << $urandom_range(0, 7));
        default: r = ($urandom_range(0, 1) == 0) ? 8'h00 : (8'd1 << $urandom_range(0, 7));
      endcase
      cycle(r, 8'($urandom));
      if (i == 1000) async_reset(1);
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", 8'(q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux_rr_arbiter
`default_nettype wire
